pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline control unit for the 5-stage CPU.
- Generates the enable and synchronous-clear inputs of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves three hazards:
  - load-use hazard: stall one cycle and inject a bubble;
  - taken branch: flush the wrong-path instructions;
  - multi-cycle data memory: freeze the pipe, with a timeout.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5: register-specifier width.
- MEM_TIMEOUT, 16: consecutive not-ready memory cycles before HALT; legal range is at least 2.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- idex_memread  in  1  instruction in EX is a load
- idex_rd  in  REG_W  destination register of the EX instruction
- ifid_rs  in  REG_W  source register 1 of the ID instruction
- ifid_rt  in  REG_W  source register 2 of the ID instruction
- ifid_uses_rt  in  1  ID instruction reads rt
- branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_rst, idex_rst, exmem_rst, memwb_rst  out  1 each  synchronous flush (bubble) requests
- err  out  1  memory-timeout error, sticky
- stall_count  out  CNT_W  cycles with pc_en=0

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high (rst).
  - While rst=1: all *_en=0, all *_rst=1, err=0. On the next edge: state=RUN, wait_cnt=0, stall_count=0.
- Outputs are a combinational decode of the registered state plus the current inputs, so zero-cycle latency. State and counters update on the rising clk edge.
- States: RUN, MEM_WAIT, HALT. Encoding is free.
- Default (RUN, no hazard): all *_en=1, all *_rst=0.
- Priority within RUN, highest first: memory stall > branch flush > load-use.
- Memory stall:
  - Trigger: mem_req=1 and mem_ready=0 in RUN.
  - Outputs: pc_en=ifid_en=idex_en=exmem_en=0; memwb_en=1, memwb_rst=1 (bubble into WB).
  - Next state MEM_WAIT, wait_cnt←1.
- MEM_WAIT:
  - mem_ready=0: same freeze outputs. wait_cnt←wait_cnt+1. If wait_cnt+1==MEM_TIMEOUT, next state HALT.
  - mem_ready=1: outputs are evaluated exactly as in RUN (branch/load-use rules apply this cycle). Next state RUN, wait_cnt←0.
- Branch flush:
  - Trigger: branch_taken=1, no memory stall.
  - Outputs: all en=1 (PC loads target), ifid_rst=1, idex_rst=1.
  - The load-use condition is ignored, because the dependent instruction is being flushed.
- Load-use stall:
  - Trigger: idex_memread=1, idex_rd!=0, and (idex_rd==ifid_rs, or ifid_uses_rt=1 and idex_rd==ifid_rt).
  - Outputs: pc_en=0, ifid_en=0, idex_rst=1; the other en=1.
  - Lasts exactly one cycle with no state change; the condition clears as the load advances.
- Simultaneous branch and memory stall: the stall wins. branch_taken stays held because EX is frozen, and the flush is applied in the cycle the pipe advances.
- HALT:
  - Outputs: all en=0, all rst=0, err=1.
  - Leaves HALT only on rst. Inputs are ignored.
- stall_count:
  - Increments by 1 each non-reset cycle with pc_en=0 and state!=HALT.
  - Saturates at all-ones, no wrap.
- Reset mid-MEM_WAIT or in HALT: rst dominates all logic; RUN is restored on the next edge.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs=5 → one cycle of pc_en=0, ifid_en=0, idex_rst=1. With idex_rd=0 → no stall. With ifid_uses_rt=0 and idex_rd==ifid_rt=7 → no stall.
- Branch: branch_taken=1 plus a load-use match → ifid_rst=idex_rst=1, pc_en=1, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 →
  - 3 freeze cycles with memwb_rst=1;
  - 4th cycle all en=1;
  - stall_count=3;
  - state returns to RUN.
- Branch during freeze: branch_taken=1 held across the wait above → no flush while frozen; ifid_rst=idex_rst=1 exactly in the ready cycle.
- Timeout: MEM_TIMEOUT=16, mem_ready held 0 → after 16 not-ready cycles err=1 and all en=0; HALT persists 20+ cycles; rst for 1 cycle → RUN, err=0, stall_count=0.
- Saturation: CNT_W=4, 20 consecutive load-use stall cycles → stall_count stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central control for the 5-stage pipeline. Drives the enable
//               and synchronous-clear of every pipeline register, resolving
//               load-use stalls, taken-branch flushes and multi-cycle data
//               memory freezes (with timeout to a sticky error state). Also
//               keeps a saturating count of cycles in which the PC is held.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_rst,
    output logic             idex_rst,
    output logic             exmem_rst,
    output logic             memwb_rst,
    output logic             err,
    output logic [CNT_W-1:0] stall_count
);

    // Wide enough to hold MEM_TIMEOUT itself, the value that trips HALT.
    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT  = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX  = '1;

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HALT     = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [c_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;

    logic                w_load_use;
    logic                w_freeze;
    logic [c_WAIT_W-1:0] w_wait_inc;

    // Hazard detection terms shared by the decode below.
    always_comb begin
        w_load_use = idex_memread && (idex_rd != '0) &&
                     ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
        // In RUN only a real access can stall; once waiting, readiness alone decides.
        w_freeze   = (state_q == c_ST_RUN)      ? (mem_req && !mem_ready) :
                     (state_q == c_ST_MEM_WAIT) ? !mem_ready : 1'b0;
        w_wait_inc = wait_cnt_q + c_WAIT_ONE;
    end

    // Output decode and next-state logic; rst overrides everything.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_rst   = 1'b0;
        idex_rst   = 1'b0;
        exmem_rst  = 1'b0;
        memwb_rst  = 1'b0;
        err        = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_rst   = 1'b1;
            idex_rst   = 1'b1;
            exmem_rst  = 1'b1;
            memwb_rst  = 1'b1;
            state_d    = c_ST_RUN;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                c_ST_RUN, c_ST_MEM_WAIT: begin
                    if (w_freeze) begin
                        // Hold everything up to MEM; let WB drain with a bubble.
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_en   = 1'b0;
                        exmem_en  = 1'b0;
                        memwb_rst = 1'b1;
                        if (state_q == c_ST_RUN) begin
                            state_d    = c_ST_MEM_WAIT;
                            wait_cnt_d = c_WAIT_ONE;
                        end else begin
                            wait_cnt_d = w_wait_inc;
                            if (w_wait_inc == c_TIMEOUT) begin
                                state_d = c_ST_HALT;
                            end
                        end
                    end else begin
                        // A held branch is applied here, in the cycle the pipe moves.
                        if (branch_taken) begin
                            ifid_rst = 1'b1;
                            idex_rst = 1'b1;
                        end else if (w_load_use) begin
                            pc_en    = 1'b0;
                            ifid_en  = 1'b0;
                            idex_rst = 1'b1;
                        end
                        state_d    = c_ST_RUN;
                        wait_cnt_d = '0;
                    end
                end
                c_ST_HALT: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    err      = 1'b1;
                end
                default: begin
                    // Unreachable encoding: hold the pipe and recover to RUN.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    exmem_en   = 1'b0;
                    memwb_en   = 1'b0;
                    state_d    = c_ST_RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    // Saturating count of cycles with the PC held, excluding HALT.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_en && (state_q != c_ST_HALT) && (stall_count_q != c_CNT_MAX)) begin
            stall_count_d = stall_count_q + c_CNT_ONE;
        end
    end

    // State, wait counter and performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= c_ST_RUN;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
`default_nettype wire
